// File: rtl/riscv_muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package riscv_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN       = 32'h80000000;

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide: 32-step shift-add / restoring divide
// sharing one 64-bit shift register and one 33-bit adder.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  state_e            state, state_n;
  logic [CW-1:0]     count;
  op_e               op;
  logic [XLEN-1:0]   mag;
  logic [2*XLEN-1:0] acc;
  logic              neg, rem_neg, special;

  logic            accept, is_div, s1, s2;
  logic            div0, ovf, spec_now;
  logic [XLEN-1:0] a_abs, b_abs, spec_val;

  assign accept = start & ~flush & (state == IDLE);
  assign is_div = funct3[2];
  assign s1 = (funct3 == MULH) | (funct3 == MULHSU) |
              (funct3 == DIV)  | (funct3 == REM);
  assign s2 = (funct3 == MULH) | (funct3 == DIV) |
              (funct3 == REM);

  assign a_abs = (s1 & op1[XLEN-1]) ? -op1 : op1;
  assign b_abs = (s2 & op2[XLEN-1]) ? -op2 : op2;

  assign div0 = is_div & (op2 == '0);
  assign ovf  = s2 & is_div & (op1 == INT_MIN) & (op2 == '1);
  assign spec_now = div0 | ovf;

  always_comb begin
    spec_val = '0;
    if (div0)
      spec_val = funct3[1] ? op1 : DIV_BY_ZERO_Q;
    else if (ovf)
      spec_val = funct3[1] ? '0 : INT_MIN;
  end

  // One adder: adds multiplicand, or subtracts divisor via ~y + 1.
  logic            op_div;
  logic [XLEN:0]   add_x, add_y, sum;
  logic [2*XLEN-1:0] step;

  assign op_div = op[2];
  assign add_x = op_div ? acc[2*XLEN-1:XLEN-1]
                        : {1'b0, acc[2*XLEN-1:XLEN]};
  assign add_y = op_div ? ~{1'b0, mag} : {1'b0, mag};
  assign sum = add_x + add_y + {{XLEN{1'b0}}, op_div};

  always_comb begin
    step = {1'b0, acc[2*XLEN-1:1]};
    if (op_div) begin
      if (!sum[XLEN])
        step = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        step = {acc[2*XLEN-2:0], 1'b0};
    end else if (acc[0]) begin
      step = {sum, acc[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fix_val;

  assign prod = neg ? -acc : acc;
  assign quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rmd  = rem_neg ? -acc[2*XLEN-1:XLEN]
                        : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = '0;
    unique case (1'b1)
      (op == MUL):  fix_val = prod[XLEN-1:0];
      (op == DIV),
      (op == DIVU): fix_val = quo;
      (op == REM),
      (op == REMU): fix_val = rmd;
      default:      fix_val = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = spec_now ? FIX : CALC;
      CALC: if (count == CW'(XLEN-1)) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      op      <= MUL;
      mag     <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      rem_neg <= 1'b0;
      special <= 1'b0;
      result  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op      <= op_e'(funct3);
        mag     <= is_div ? b_abs : a_abs;
        acc     <= spec_now ? {{XLEN{1'b0}}, spec_val}
                 : {{XLEN{1'b0}}, is_div ? a_abs : b_abs};
        neg     <= (s1 & op1[XLEN-1]) ^ (s2 & op2[XLEN-1]);
        rem_neg <= s1 & op1[XLEN-1];
        special <= spec_now;
        count   <= '0;
      end else if (state == CALC) begin
        acc   <= step;
        count <= count + 1'b1;
      end
      if (state == FIX && !flush)
        result <= special ? acc[XLEN-1:0] : fix_val;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_riscv_muldiv.sv
// Randomized and directed checks of riscv_muldiv against an
// arithmetic reference model.
module tb_riscv_muldiv;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic        flush = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] op1 = 0;
  logic [31:0] op2 = 0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  riscv_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .funct3(funct3), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 &&
        b == 32'hFFFFFFFF) return 2;
    return 34;
  endfunction

  // Issue one op from idle; lat = cycle index of done after accept.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat);
    int n;
    funct3 = f; op1 = a; op2 = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    lat = done ? n : 999;
    res = result;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    tests++;
    if ({busy, done, result} !== 34'h0) begin
      fails++;
      $display("FAIL reset busy=%b done=%b result=%h want 0 0 0",
               busy, done, result);
    end
    rst = 0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_directed;
    logic [2:0]  f[13] = '{0, 3, 1, 2, 3, 4, 6, 5, 7, 4, 7, 4, 6};
    logic [31:0] a[13] = '{7, 32'hFFFFFFFF, 32'hFFFFFFFF,
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
      100, 100, 5, 5, 32'h80000000, 32'h80000000};
    logic [31:0] b[13] = '{6, 32'hFFFFFFFF, 2, 2, 2, 2, 2, 7, 7,
      0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e[13] = '{42, 32'hFFFFFFFE, 32'hFFFFFFFF,
      32'hFFFFFFFF, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 14, 2,
      32'hFFFFFFFF, 5, 32'h80000000, 0};
    int          l[13] = '{34, 34, 34, 34, 34, 34, 34, 34, 34,
      2, 2, 2, 2};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 13; i++) begin
      run_op(f[i], a[i], b[i], r, lat);
      tests++;
      if (r !== e[i] || lat !== l[i]) begin
        fails++;
        $display("FAIL directed[%0d] result=%h lat=%0d want %h lat=%0d",
                 i, r, lat, e[i], l[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] edge_v[5] = '{0, 1, 32'h80000000, 32'hFFFFFFFF,
                               32'h7FFFFFFF};
    logic [2:0]  f;
    logic [31:0] a, b, r;
    int lat;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom);
      a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)]
                                      : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)]
                                      : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      run_op(f, a, b, r, lat);
      tests++;
      if (r !== model(f, a, b) || lat !== model_lat(f, a, b)) begin
        fails++;
        $display("FAIL random f3=%0d a=%h b=%h result=%h lat=%0d want %h lat=%0d",
                 f, a, b, r, lat, model(f, a, b), model_lat(f, a, b));
      end
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    funct3 = 3'd0; op1 = 5; op2 = 5; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int n = 1; n < 60; n++) begin
      if (done) ndone++;
      start = (n == 5) || done;
      funct3 = 3'd4; op1 = 9; op2 = 0;
      @(posedge clk); #1;
    end
    start = 0;
    tests++;
    if (ndone !== 1 || result !== 32'd25) begin
      fails++;
      $display("FAIL ignore_busy dones=%0d result=%h want 1 %h",
               ndone, result, 32'd25);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_busy_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_flush;
    logic [31:0] prev;
    int ndone = 0;
    prev = result;
    funct3 = 3'd5; op1 = 1000; op2 = 3; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int n = 1; n < 11; n++) begin
      @(posedge clk); #1;
    end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_busy busy=%b want 0", busy);
    end
    for (int n = 0; n < 40; n++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    tests++;
    if (ndone !== 0 || result !== prev) begin
      fails++;
      $display("FAIL flush_nodone dones=%0d result=%h want 0 %h",
               ndone, result, prev);
    end
    funct3 = 3'd0; op1 = 2; op2 = 2; start = 1; flush = 1;
    @(posedge clk); #1;
    start = 0; flush = 0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL start_flush busy=%b want 0", busy);
    end
  endtask

  task automatic test_rst_mid;
    logic [31:0] r;
    int lat;
    funct3 = 3'd4; op1 = 32'h12345678; op2 = 77; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int n = 1; n < 21; n++) begin
      @(posedge clk); #1;
    end
    rst = 1;
    #1;
    tests++;
    if ({busy, done, result} !== 34'h0) begin
      fails++;
      $display("FAIL rst_mid busy=%b done=%b result=%h want 0 0 0",
               busy, done, result);
    end
    #1 rst = 0;
    @(posedge clk); #1;
    run_op(3'd0, 3, 3, r, lat);
    tests++;
    if (r !== 32'd9 || lat !== 34) begin
      fails++;
      $display("FAIL rst_mul result=%h lat=%0d want %h lat=34",
               r, lat, 32'd9);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_flush;
    test_random;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
